// File: rtl/reg_aync_skid.sv
// Two-entry registered skid buffer: o_ready is decoded from registered state only.
// Optional upstream stall counter when REG_AYNC_SKID_STAT_EN is defined.
module reg_aync_skid #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RSTN_VALUE = '0
`ifdef REG_AYNC_SKID_STAT_EN
  , parameter int                  CNT_WIDTH  = 16
`endif
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data
`ifdef REG_AYNC_SKID_STAT_EN
  , output logic [CNT_WIDTH-1:0] o_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_main;
  logic [DATA_WIDTH-1:0] r_skid;
  logic                  w_in_fire;
  logic                  w_out_fire;
  logic                  w_load_main;
  logic                  w_main_from_skid;
  logic                  w_load_skid;

  // A beat transfers on a cycle where valid and ready are both high at the
  // posedge; valid never waits on ready, and once raised stays high with
  // stable data until the transfer happens.
  assign o_valid    = (r_state != ST_EMPTY);
  assign o_ready    = (r_state != ST_TWO);
  assign o_data     = r_main;
  assign w_in_fire  = i_valid && o_ready;
  assign w_out_fire = o_valid && i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main      = 1'b0;
    w_main_from_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (i_flush) begin
      // Flush drops occupancy only; payload registers keep their contents.
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt = ST_ONE;
            w_load_main = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_load_main = 1'b1;
          end else if (w_in_fire) begin
            w_state_nxt = ST_TWO;
            w_load_skid = 1'b1;
          end else if (w_out_fire) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_out_fire) begin
            w_state_nxt      = ST_ONE;
            w_load_main      = 1'b1;
            w_main_from_skid = 1'b1;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_main <= RSTN_VALUE;
      r_skid <= RSTN_VALUE;
    end else begin
      if (w_load_main) begin
        r_main <= w_main_from_skid ? r_skid : i_data;
      end
      if (w_load_skid) begin
        r_skid <= i_data;
      end
    end
  end

`ifdef REG_AYNC_SKID_STAT_EN
  logic [CNT_WIDTH-1:0] r_stall_cnt;
  logic                 w_stall;

  assign w_stall     = i_valid && !o_ready;
  assign o_stall_cnt = r_stall_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cnt <= '0;
    end else if (i_flush) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {CNT_WIDTH{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_reg_aync_skid.sv
// Directed bench for reg_aync_skid: driver tasks push accepted beats into
// exp_q, a negedge monitor pops and compares every downstream transfer.
module tb_reg_aync_skid;
  localparam int         DW   = 8;
  localparam logic [7:0] RSTV = 8'h5A;
`ifdef REG_AYNC_SKID_STAT_EN
  localparam int         CW   = 4;
`endif

  logic          i_clk;
  logic          i_rst_n;
  logic          i_flush;
  logic          i_valid;
  logic          o_ready;
  logic [DW-1:0] i_data;
  logic          o_valid;
  logic          i_ready;
  logic [DW-1:0] o_data;
`ifdef REG_AYNC_SKID_STAT_EN
  logic [CW-1:0] o_stall_cnt;
`endif

  logic [DW-1:0] exp_q[$];
  int            n_vec;
  int            n_fail;
  int            n_out;

  reg_aync_skid #(
    .DATA_WIDTH(DW),
    .RSTN_VALUE(RSTV)
`ifdef REG_AYNC_SKID_STAT_EN
    , .CNT_WIDTH(CW)
`endif
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (i_flush),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data)
`ifdef REG_AYNC_SKID_STAT_EN
    , .o_stall_cnt(o_stall_cnt)
`endif
  );

  // clock / reset
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finished", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // One clock: record an upstream accept at negedge, then return at posedge+1.
  task automatic step();
    @(negedge i_clk);
    if (i_rst_n) begin
      if (i_flush) exp_q.delete();
      else if (i_valid && o_ready) exp_q.push_back(i_data);
    end
    @(posedge i_clk);
    #1;
  endtask

  // scoreboard monitor
  always @(negedge i_clk) begin
    logic [DW-1:0] exp_d;
    if (i_rst_n && o_valid && i_ready && !i_flush) begin
      n_out++;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_out: got %0h, required no output", o_data);
      end else begin
        exp_d = exp_q.pop_front();
        if (o_data !== exp_d) begin
          n_fail++;
          $display("FAIL out_data: got %0h, required %0h", o_data, exp_d);
        end
      end
    end
  end

  initial begin
    int out_base;
    int not_ready;
    n_vec = 0; n_fail = 0; n_out = 0;
    i_rst_n = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_data = '0;
    #23;
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_data",  32'(o_data),  32'(RSTV));
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;

    // first beat, one-cycle latency
    i_valid = 1'b1; i_data = 8'hA5; i_ready = 1'b1;
    step();
    check("lat_valid", 32'(o_valid), 32'd1);
    check("lat_data",  32'(o_data),  32'hA5);
    i_valid = 1'b0;
    step();
    check("lat_drain", 32'(o_valid), 32'd0);

    // fill both entries under backpressure
    i_ready = 1'b0;
    i_valid = 1'b1; i_data = 8'h11; step();
    i_data = 8'h22; step();
    check("two_valid", 32'(o_valid), 32'd1);
    check("two_ready", 32'(o_ready), 32'd0);
    check("two_data",  32'(o_data),  32'h11);
    i_valid = 1'b0; i_ready = 1'b1;
    step();
    check("drain1_data",  32'(o_data),  32'h22);
    check("drain1_ready", 32'(o_ready), 32'd1);
    step();
    check("drain2_valid", 32'(o_valid), 32'd0);
    check("empty_hold",   32'(o_data),  32'h22);

    // full-rate streaming
    out_base = n_out;
    not_ready = 0;
    i_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (!o_ready) not_ready++;
      i_valid = 1'b1; i_data = 8'(k);
      step();
    end
    i_valid = 1'b0;
    step();
    check("stream_count",    32'(n_out - out_base), 32'd100);
    check("stream_notready", 32'(not_ready),        32'd0);
    check("stream_qempty",   32'(exp_q.size()),     32'd0);

    // flush while full, with a same-cycle upstream beat
    i_ready = 1'b0;
    i_valid = 1'b1; i_data = 8'h33; step();
    i_data = 8'h44; step();
    check("pre_flush_ready", 32'(o_ready), 32'd0);
`ifdef REG_AYNC_SKID_STAT_EN
    i_data = 8'h66;
    for (int k = 0; k < 20; k++) step();
    check("stall_sat", 32'(o_stall_cnt), 32'd15);
`endif
    i_flush = 1'b1; i_valid = 1'b1; i_data = 8'h55;
    step();
    i_flush = 1'b0; i_valid = 1'b0;
    check("flush_valid", 32'(o_valid), 32'd0);
    check("flush_ready", 32'(o_ready), 32'd1);
    check("flush_data",  32'(o_data),  32'h33);
`ifdef REG_AYNC_SKID_STAT_EN
    check("stall_clear", 32'(o_stall_cnt), 32'd0);
`endif
    i_ready = 1'b1;
    for (int k = 0; k < 3; k++) step();
    check("post_flush_valid", 32'(o_valid), 32'd0);

    // asynchronous reset in the middle of a cycle while holding a beat
    i_ready = 1'b0;
    i_valid = 1'b1; i_data = 8'h77; step();
    i_valid = 1'b0;
    check("pre_rst_valid", 32'(o_valid), 32'd1);
    #1 i_rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(o_valid), 32'd0);
    check("arst_ready", 32'(o_ready), 32'd1);
    check("arst_data",  32'(o_data),  32'(RSTV));
    exp_q.delete();
    #1 i_rst_n = 1'b1;
    i_valid = 1'b1; i_data = 8'h88; i_ready = 1'b1;
    step();
    check("post_rst_valid", 32'(o_valid), 32'd1);
    check("post_rst_data",  32'(o_data),  32'h88);
    i_valid = 1'b0;
    step();
    step();
    check("final_qempty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
